wb_trace_buffer: RTL and testbench
==================================

// Module: wb_trace_buffer
// PURPOSE
//  Captures committed register-file writebacks (pc, dest reg, data) from the CPU writeback stage.
//  Buffers them in a small FIFO and presents them one per handshake to the downstream trace logger.
//  The logger may stall via out_ready; overflow is counted, never blocks the CPU.
//  Sits between the writeback stage and the simulation trace/file-dump stage.
// PARAMETERS
//  DATA_W  32  width of wb_data / out_data and of pc / out_pc
//  ADDR_W  5   register address width
//  DEPTH   8   FIFO entries; power of 2, >= 2
//  CNT_W   16  width of out_seq and drop_cnt
// PORTS
//  clk       in   1        clock; all state updates on rising edge
//  rst       in   1        asynchronous, active-high reset
//  wb_en     in   1        writeback valid this cycle
//  wb_addr   in   ADDR_W   destination register
//  wb_data   in   DATA_W   value written
//  wb_pc     in   DATA_W   pc of the committing instruction
//  out_valid out  1        head entry valid (== !empty)
//  out_ready in   1        logger accepts head this cycle
//  out_pc    out  DATA_W   head entry pc
//  out_addr  out  ADDR_W   head entry register
//  out_data  out  DATA_W   head entry data
//  out_seq   out  CNT_W    head entry sequence number
//  drop_cnt  out  CNT_W    events lost to overflow, saturating
//  count     out  log2(DEPTH)+1  current occupancy
//  full      out  1        count == DEPTH
// BEHAVIOUR
//  - Reset (async, immediate): rd/wr pointers, count, seq counter, drop_cnt = 0; out_valid=0,
//    full=0; out_pc/out_addr/out_data/out_seq = 0. Reset mid-traffic discards all buffered entries.
//  - Qualifying event: wb_en=1 && wb_addr!=0 (writes to r0 are ignored, no seq consumed).
//  - seq_ctr increments by 1 (mod 2^CNT_W) on every qualifying event, accepted or dropped;
//    each stored entry carries the pre-increment value, so gaps in out_seq expose drops.
//  - pop = out_valid && out_ready. push = qualifying && (!full || pop).
//  - Full + qualifying + pop same cycle: push and pop both happen, count unchanged.
//  - Full + qualifying + no pop: event dropped; drop_cnt += 1, holds at 2^CNT_W-1.
//  - Empty + qualifying + out_ready: no bypass; entry is stored, appears next cycle.
//  - Latency: event sampled at edge k -> out_valid=1 with its fields from edge k (visible cycle k+1).
//  - Show-ahead FIFO: out_* always reflect head entry; stable while out_valid && !out_ready.
//  - When empty, out_pc/out_addr/out_data/out_seq hold last popped values (don't care to logger).
//  - Pointers wrap modulo DEPTH; count = push - pop delta per cycle, range 0..DEPTH.
//  - out_ready while out_valid=0 has no effect.
//  - No combinational path from wb_* to out_*; out_valid depends only on registered count.
// TESTING
//  1 reset: assert rst mid-cycle with 3 entries queued -> out_valid=0, count=0, drop_cnt=0 immediately.
//  2 single: wb_en=1 addr=5 data=0xDEADBEEF pc=0x00400000, out_ready=1 -> next cycle out_valid=1,
//    out_addr=5, out_data=0xDEADBEEF, out_seq=0; following cycle out_valid=0.
//  3 r0 filter: wb_en=1 addr=0 for 4 cycles -> count stays 0, next real write gets out_seq=0.
//  4 overflow: out_ready=0, 10 writes addr=1..10 -> full=1 after 8, drop_cnt=2; drain shows
//    seq 0..7 in order, addr 1..8.
//  5 full push+pop: fill 8, then write addr=9 with out_ready=1 -> count stays 8, drop_cnt=0,
//    popped seq=0, tail entry seq=8.
//  6 wrap: stream 20 writes with out_ready toggling 1/0 each cycle -> every accepted entry popped
//    exactly once, seq strictly increasing, no entry corrupted across pointer wrap.

Source files
------------

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: show-ahead FIFO capturing committed writebacks for the trace logger
module wb_trace_buffer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic [DATA_W-1:0]        wb_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_pc,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [DATA_W-1:0]        out_data,
    output logic [CNT_W-1:0]         out_seq,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] mem_pc   [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [CNT_W-1:0]  mem_seq  [DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  seq_ctr;
    logic [DATA_W-1:0] last_pc, last_data;
    logic [ADDR_W-1:0] last_addr;
    logic [CNT_W-1:0]  last_seq;
    logic              qual, pop, push;

    assign out_valid = count != '0;
    assign full      = count == CW'(DEPTH);
    assign qual      = wb_en && (wb_addr != '0);
    assign pop       = out_valid && out_ready;
    assign push      = qual && (!full || pop);

    // Head entry while non-empty, otherwise the last entry handed to the logger
    always_comb begin
        out_pc   = out_valid ? mem_pc[rd_ptr]   : last_pc;
        out_addr = out_valid ? mem_addr[rd_ptr] : last_addr;
        out_data = out_valid ? mem_data[rd_ptr] : last_data;
        out_seq  = out_valid ? mem_seq[rd_ptr]  : last_seq;
    end

    // Storage array; contents need no reset since reads are gated by occupancy
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]   <= wb_pc;
            mem_addr[wr_ptr] <= wb_addr;
            mem_data[wr_ptr] <= wb_data;
            mem_seq[wr_ptr]  <= seq_ctr;
        end
    end

    // Pointers, occupancy, sequence/drop counters and last-popped capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            seq_ctr   <= '0;
            drop_cnt  <= '0;
            last_pc   <= '0;
            last_addr <= '0;
            last_data <= '0;
            last_seq  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr    <= rd_ptr + PW'(1);
                last_pc   <= mem_pc[rd_ptr];
                last_addr <= mem_addr[rd_ptr];
                last_data <= mem_data[rd_ptr];
                last_seq  <= mem_seq[rd_ptr];
            end
            count <= count + CW'(push) - CW'(pop);
            if (qual) seq_ctr <= seq_ctr + CNT_W'(1);
            if (qual && !push && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb_wb_trace_buffer: directed and randomized checks against a queue-based model
module tb_wb_trace_buffer;
    localparam int DW = 32, AW = 5, D = 8, CW = 16;

    typedef struct {
        logic [DW-1:0] pc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [CW-1:0] seq;
    } ent_t;

    logic clk = 0, rst = 1, wb_en = 0, out_ready = 0;
    logic [AW-1:0] wb_addr = '0;
    logic [DW-1:0] wb_data = '0, wb_pc = '0;
    logic out_valid, full;
    logic [DW-1:0] out_pc, out_data;
    logic [AW-1:0] out_addr;
    logic [CW-1:0] out_seq, drop_cnt;
    logic [$clog2(D):0] count;

    ent_t q[$];
    ent_t last;
    int m_seq, m_drop, popped;
    int checks = 0, failures = 0;

    wb_trace_buffer #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .wb_pc(wb_pc), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_addr(out_addr), .out_data(out_data), .out_seq(out_seq),
        .drop_cnt(drop_cnt), .count(count), .full(full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        last = '{pc: '0, addr: '0, data: '0, seq: '0};
        m_seq = 0;
        m_drop = 0;
    endtask

    task automatic check_all();
        ent_t h;
        h = (q.size() != 0) ? q[0] : last;
        check("valid", out_valid, q.size() != 0);
        check("count", count, q.size());
        check("full", full, q.size() == D);
        check("drop", drop_cnt, m_drop);
        check("pc", out_pc, h.pc);
        check("addr", out_addr, h.addr);
        check("data", out_data, h.data);
        check("seq", out_seq, h.seq);
    endtask

    task automatic cyc(input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW-1:0] p, input logic r);
        bit pp, ps, ql;
        @(negedge clk);
        wb_en = en; wb_addr = a; wb_data = d; wb_pc = p; out_ready = r;
        ql = en && a != 0;
        pp = q.size() != 0 && r;
        ps = ql && (q.size() < D || pp);
        @(posedge clk);
        #1;
        if (pp) begin
            last = q.pop_front();
            popped++;
        end
        if (ps) q.push_back('{pc: p, addr: a, data: d, seq: CW'(m_seq)});
        if (ql && !ps && m_drop < 65535) m_drop++;
        if (ql) m_seq = (m_seq + 1) % 65536;
        check_all();
    endtask

    task automatic idle(input logic r);
        cyc(0, '0, '0, '0, r);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_count", count, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_outs", {out_pc, out_addr, out_data, out_seq}, 0);
        model_clear();
        @(negedge clk);
        wb_en = 0; out_ready = 0;
        rst = 0;
        check_all();
    endtask

    initial begin
        model_clear();
        popped = 0;
        @(negedge clk);
        rst = 0;
        check_all();

        for (int i = 1; i <= 3; i++) cyc(1, AW'(i), $urandom, $urandom, 0);
        check("t1_pre", count, 3);
        do_reset();

        cyc(1, 5, 32'hDEADBEEF, 32'h0040_0000, 1);
        check("t2_valid", out_valid, 1);
        check("t2_entry", {out_addr, out_data, out_seq}, {5'd5, 32'hDEADBEEF, 16'd0});
        idle(1);
        check("t2_empty", out_valid, 0);

        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, 0, $urandom, $urandom, 0);
        check("t3_count", count, 0);
        cyc(1, 3, $urandom, $urandom, 0);
        check("t3_seq", out_seq, 0);

        do_reset();
        for (int i = 1; i <= 10; i++) begin
            cyc(1, AW'(i), $urandom, $urandom, 0);
            if (i == 8) check("t4_full8", full, 1);
        end
        check("t4_drop", drop_cnt, 2);
        for (int i = 0; i < 8; i++) begin
            check("t4_order", {out_addr, out_seq}, {AW'(i + 1), CW'(i)});
            idle(1);
        end

        do_reset();
        for (int i = 1; i <= 8; i++) cyc(1, AW'(i), $urandom, $urandom, 0);
        cyc(1, 9, $urandom, $urandom, 1);
        check("t5_count", count, 8);
        check("t5_drop", drop_cnt, 0);
        check("t5_popseq", last.seq, 0);
        for (int i = 0; i < 8; i++) idle(1);
        check("t5_tailseq", last.seq, 8);

        do_reset();
        popped = 0;
        for (int i = 0; i < 20; i++) cyc(1, AW'($urandom_range(1, 31)), $urandom, $urandom, i[0] == 0);
        for (int i = 0; i < 40 && q.size() != 0; i++) idle(1);
        check("t6_drained", count, 0);
        check("t6_popped", popped + m_drop, 20);

        do_reset();
        for (int i = 0; i < 500; i++)
            cyc($urandom_range(0, 3) != 0, AW'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 31)),
                $urandom, $urandom, $urandom_range(0, 2) == 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
